// File: rtl/mmcm_phaseshift_ctrl_if.sv
`timescale 1ns/1ps
// Control/status bundle between a phase-shift requester and the MMCM phase-shift controller.
// Master drives the request and MMCM status inputs; slave (the controller) drives PSEN/PSINCDEC and status.
interface mmcm_phaseshift_ctrl_if;
    logic [8:0] value_i;
    logic       load_i;
    logic       locked_i;
    logic       psdone_i;
    logic       psen_o;
    logic       psincdec_o;
    logic [8:0] value_o;
    logic       done_o;
    logic       error_o;

    modport master (
        output value_i, load_i, locked_i, psdone_i,
        input  psen_o, psincdec_o, value_o, done_o, error_o
    );

    modport slave (
        input  value_i, load_i, locked_i, psdone_i,
        output psen_o, psincdec_o, value_o, done_o, error_o
    );
endinterface

// File: rtl/mmcm_phaseshift_ctrl.sv
`timescale 1ns/1ps
// Walks the MMCM dynamic phase one PSEN step at a time toward a loaded signed target (optional MMCM_PS_TIMEOUT_EN psdone timeout).
// Latency: 1 IDLE + 1 STEP + psdone latency per step; done_o is registered, one cycle behind the state.
// Backpressure: each step waits for psdone_i; loss of lock drops the step and rewinds to pDEFAULT.
module mmcm_phaseshift_ctrl #(
    parameter logic signed [8:0] pDEFAULT = 9'sd0,
    parameter logic        [7:0] pTIMEOUT = 8'd255
) (
    input  logic                   clk_usb,
    input  logic                   reset_i,
    mmcm_phaseshift_ctrl_if.slave  ps
);
    typedef enum logic [1:0] {IDLE, STEP, WAIT_DONE} state_t;

    state_t            state, state_n;
    logic signed [8:0] target, actual, load_val;
    logic              inc;
    logic              done_q;
    logic              step_done;
`ifdef MMCM_PS_TIMEOUT_EN
    logic [7:0]        cnt;
    logic              timeout;
    logic              error_q;
`endif

    // -256 has no matching MMCM position, so it folds onto the lowest legal phase
    assign load_val = (ps.value_i == 9'h100) ? -9'sd255 : $signed(ps.value_i);

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n   = state;
        step_done = 1'b0;
`ifdef MMCM_PS_TIMEOUT_EN
        timeout   = 1'b0;
`endif
        case (state)
            IDLE:      if (target != actual) state_n = STEP;
            STEP:      state_n = WAIT_DONE;
            WAIT_DONE: begin
                if (ps.psdone_i) begin
                    state_n   = IDLE;
                    step_done = 1'b1;
                end
`ifdef MMCM_PS_TIMEOUT_EN
                else if (cnt == pTIMEOUT - 8'd1) begin
                    state_n = IDLE;
                    timeout = 1'b1;
                end
`endif
            end
            default:   state_n = IDLE;
        endcase
        if (!ps.locked_i) begin
            state_n   = IDLE;
            step_done = 1'b0;
`ifdef MMCM_PS_TIMEOUT_EN
            timeout   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            target <= pDEFAULT;
            actual <= pDEFAULT;
            inc    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == IDLE) && ps.locked_i && (target == actual);
            if (state == IDLE && state_n == STEP)
                inc <= (target > actual);
            if (!ps.locked_i)
                actual <= pDEFAULT;
            else if (step_done) begin
                if (inc && actual != 9'sd255)
                    actual <= actual + 9'sd1;
                else if (!inc && actual != -9'sd255)
                    actual <= actual - 9'sd1;
            end
`ifdef MMCM_PS_TIMEOUT_EN
            // Give up on the target after a lost step so the FSM stops retrying
            if (timeout)
                target <= actual;
`endif
            if (ps.load_i)
                target <= load_val;
        end
    end

`ifdef MMCM_PS_TIMEOUT_EN
    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            cnt     <= 8'd0;
            error_q <= 1'b0;
        end else begin
            cnt <= (state == WAIT_DONE && state_n == WAIT_DONE) ? cnt + 8'd1 : 8'd0;
            if (timeout)
                error_q <= 1'b1;
            else if (ps.load_i)
                error_q <= 1'b0;
        end
    end

    assign ps.error_o = error_q;
`else
    // pTIMEOUT only matters when the timeout is built in
    assign ps.error_o = 1'b0 & (pTIMEOUT == 8'd0);
`endif

    assign ps.psen_o     = (state == STEP) && ps.locked_i;
    assign ps.psincdec_o = inc;
    assign ps.value_o    = actual;
    assign ps.done_o     = done_q;
endmodule
